// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve, rally, point and match-over timing with scoring
//
// Purpose:
//   Turns frame boundaries, the start button and ball/paddle tile positions into
//   the ball-controller enable, serve direction, per-player scores and a winner.
//
// Optional feature macro: PONG_WIN_BY_TWO_EN
//   undefined : a player wins on reaching exactly c_SCORE_LIMIT
//   defined   : a player wins at >= c_SCORE_LIMIT with a lead of two, or at 15
//
// Ports:
//   i_Clk          system/pixel clock
//   i_Rst_L        asynchronous active-low reset
//   i_VSync        vertical sync, falling edge marks a frame
//   i_Game_Start   start button level, rising edge starts a match from IDLE
//   i_Ball_X/Y     ball position in tiles
//   i_Paddle_Y_P1  top row of player 1 paddle
//   i_Paddle_Y_P2  top row of player 2 paddle
//   o_Game_Active  high only while the rally is running
//   o_Serve_Dir    1 = serve toward P2, 0 = toward P1
//   o_P1_Score     player 1 score
//   o_P2_Score     player 2 score
//   o_Winner       00 none, 01 P1, 10 P2
//   o_State        current state encoding
module pong_match_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_FRAMES  = 60,
    parameter int c_WIN_FRAMES    = 180
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Ball_X,
    input  logic [5:0] i_Ball_Y,
    input  logic [5:0] i_Paddle_Y_P1,
    input  logic [5:0] i_Paddle_Y_P2,
    output logic       o_Game_Active,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    localparam int c_CNT_MAX = (c_SERVE_FRAMES > c_WIN_FRAMES) ? c_SERVE_FRAMES : c_WIN_FRAMES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SERVE_LOAD = c_CNT_W'(c_SERVE_FRAMES);
    localparam logic [c_CNT_W-1:0] c_WIN_LOAD   = c_CNT_W'(c_WIN_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [5:0]         c_P2_GOAL    = 6'(c_GAME_WIDTH - 1);
    localparam logic [6:0]         c_PAD_SPAN   = 7'(c_PADDLE_HEIGHT - 1);
    localparam logic [3:0]         c_LIMIT      = 4'(c_SCORE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE      = 3'd1,
        S_RUNNING    = 3'd2,
        S_POINT      = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]           p1_score_q, p1_score_d;
    logic [3:0]           p2_score_q, p2_score_d;
    logic [1:0]           winner_q, winner_d;
    logic                 serve_dir_q, serve_dir_d;
    // 1 when player 1 won the point being scored, 0 when player 2 did
    logic                 scorer_p1_q, scorer_p1_d;

    logic vsync_q, vsync_prev_q;
    logic start_q, start_prev_q;
    logic frame_tick, start_pulse;

    logic [6:0] ball_y7, p1_lo, p1_hi, p2_lo, p2_hi;
    logic       p1_miss, p2_miss;
    logic [3:0] new_score, other_score;
    logic       win;

    assign frame_tick  = vsync_prev_q & ~vsync_q;
    assign start_pulse = start_q & ~start_prev_q;

    // Paddle span is compared at 7 bits so a paddle near the bottom never wraps to row 0.
    assign ball_y7 = {1'b0, i_Ball_Y};
    assign p1_lo   = {1'b0, i_Paddle_Y_P1};
    assign p1_hi   = p1_lo + c_PAD_SPAN;
    assign p2_lo   = {1'b0, i_Paddle_Y_P2};
    assign p2_hi   = p2_lo + c_PAD_SPAN;
    assign p1_miss = (i_Ball_X == 6'd0)      && ((ball_y7 < p1_lo) || (ball_y7 > p1_hi));
    assign p2_miss = (i_Ball_X == c_P2_GOAL) && ((ball_y7 < p2_lo) || (ball_y7 > p2_hi));

    assign new_score   = (scorer_p1_q ? p1_score_q : p2_score_q) + 4'd1;
    assign other_score = scorer_p1_q ? p2_score_q : p1_score_q;

`ifdef PONG_WIN_BY_TWO_EN
    // Lead computed at 5 bits so other_score + 2 cannot wrap.
    assign win = ((new_score >= c_LIMIT) &&
                  ({1'b0, new_score} >= ({1'b0, other_score} + 5'd2))) ||
                 (new_score == 4'hF);
`else
    assign win = (new_score == c_LIMIT);
    logic unused_other;
    assign unused_other = ^other_score;
`endif

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b1;
            scorer_p1_q  <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            scorer_p1_q  <= scorer_p1_d;
            vsync_q      <= i_VSync;
            vsync_prev_q <= vsync_q;
            start_q      <= i_Game_Start;
            start_prev_q <= start_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        scorer_p1_d = scorer_p1_q;

        case (state_q)
            S_IDLE: begin
                // A frame tick in the same cycle is simply not looked at here.
                if (start_pulse) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    winner_d   = 2'b00;
                    cnt_d      = c_SERVE_LOAD;
                    state_d    = S_SERVE;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        state_d = S_RUNNING;
                    end
                end
            end
            S_RUNNING: begin
                if (p1_miss) begin
                    scorer_p1_d = 1'b0;
                    state_d     = S_POINT;
                end else if (p2_miss) begin
                    scorer_p1_d = 1'b1;
                    state_d     = S_POINT;
                end
            end
            S_POINT: begin
                if (scorer_p1_q) begin
                    p1_score_d = new_score;
                end else begin
                    p2_score_d = new_score;
                end
                if (win) begin
                    winner_d = scorer_p1_q ? 2'b01 : 2'b10;
                    cnt_d    = c_WIN_LOAD;
                    state_d  = S_MATCH_OVER;
                end else begin
                    // Serve toward the player who lost the point.
                    serve_dir_d = scorer_p1_q;
                    cnt_d       = c_SERVE_LOAD;
                    state_d     = S_SERVE;
                end
            end
            S_MATCH_OVER: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs, all decoded straight from registers
    always_comb begin
        o_Game_Active = (state_q == S_RUNNING);
        o_State       = state_q;
        o_Serve_Dir   = serve_dir_q;
        o_P1_Score    = p1_score_q;
        o_P2_Score    = p2_score_q;
        o_Winner      = winner_q;
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - scoreboard bench for pong_match_ctrl with a game-level reference model
module tb_pong_match_ctrl;

    localparam int GW    = 40;
    localparam int PH    = 6;
    localparam int LIMIT = 3;
    localparam int SERVE = 3;
    localparam int WINF  = 2;

    localparam int M_IDLE = 0, M_SERVE = 1, M_RUNNING = 2, M_POINT = 3, M_OVER = 4;
    localparam logic [14:0] RESET_TUPLE = {3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_VSync = 1'b0;
    logic       i_Game_Start = 1'b0;
    logic [5:0] i_Ball_X = 6'd20;
    logic [5:0] i_Ball_Y = 6'd20;
    logic [5:0] i_Paddle_Y_P1 = 6'd10;
    logic [5:0] i_Paddle_Y_P2 = 6'd10;
    logic       o_Game_Active;
    logic       o_Serve_Dir;
    logic [3:0] o_P1_Score;
    logic [3:0] o_P2_Score;
    logic [1:0] o_Winner;
    logic [2:0] o_State;

    int checks = 0;
    int errors = 0;

    // Reference model: game-level bookkeeping only
    int m_state = M_IDLE;
    int m_p1 = 0, m_p2 = 0, m_win = 0, m_dir = 1, m_cnt = 0;
    logic [14:0] sb[$];
    logic [14:0] prev_tuple = RESET_TUPLE;

    pong_match_ctrl #(
        .c_GAME_WIDTH(GW),
        .c_PADDLE_HEIGHT(PH),
        .c_SCORE_LIMIT(LIMIT),
        .c_SERVE_FRAMES(SERVE),
        .c_WIN_FRAMES(WINF)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_VSync(i_VSync),
        .i_Game_Start(i_Game_Start),
        .i_Ball_X(i_Ball_X),
        .i_Ball_Y(i_Ball_Y),
        .i_Paddle_Y_P1(i_Paddle_Y_P1),
        .i_Paddle_Y_P2(i_Paddle_Y_P2),
        .o_Game_Active(o_Game_Active),
        .o_Serve_Dir(o_Serve_Dir),
        .o_P1_Score(o_P1_Score),
        .o_P2_Score(o_P2_Score),
        .o_Winner(o_Winner),
        .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [14:0] dut_tuple();
        return {o_State, o_Game_Active, o_Serve_Dir, o_P1_Score, o_P2_Score, o_Winner};
    endfunction

    function automatic logic [14:0] model_tuple();
        return {3'(m_state), (m_state == M_RUNNING), 1'(m_dir), 4'(m_p1), 4'(m_p2), 2'(m_win)};
    endfunction

    task automatic push_expect();
        sb.push_back(model_tuple());
    endtask

    task automatic model_start();
        if (m_state == M_IDLE) begin
            m_p1 = 0; m_p2 = 0; m_win = 0;
            m_cnt = SERVE;
            m_state = M_SERVE;
            push_expect();
        end
    endtask

    task automatic model_frame();
        if (m_state == M_SERVE || m_state == M_OVER) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_state = (m_state == M_SERVE) ? M_RUNNING : M_IDLE;
                push_expect();
            end
        end
    endtask

    task automatic model_ball(input int x, input int y, input int t1, input int t2);
        bit miss1, miss2, p1_scores, won;
        int mine, other;
        if (m_state != M_RUNNING) return;
        miss1 = (x == 0) && (y < t1 || y > t1 + PH - 1);
        miss2 = (x == GW - 1) && (y < t2 || y > t2 + PH - 1);
        if (!miss1 && !miss2) return;
        p1_scores = !miss1;
        m_state = M_POINT;
        push_expect();
        if (p1_scores) m_p1++; else m_p2++;
        mine  = p1_scores ? m_p1 : m_p2;
        other = p1_scores ? m_p2 : m_p1;
`ifdef PONG_WIN_BY_TWO_EN
        won = (mine >= LIMIT && mine - other >= 2) || mine == 15;
`else
        won = (mine == LIMIT);
`endif
        if (won) begin
            m_win = p1_scores ? 1 : 2;
            m_cnt = WINF;
            m_state = M_OVER;
        end else begin
            m_dir = p1_scores ? 1 : 0;
            m_cnt = SERVE;
            m_state = M_SERVE;
        end
        push_expect();
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_cnt = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic frame();
        i_VSync = 1'b1;
        cyc(2);
        i_VSync = 1'b0;
        model_frame();
        cyc(3);
    endtask

    task automatic press();
        i_Game_Start = 1'b1;
        model_start();
        cyc(2);
        i_Game_Start = 1'b0;
        cyc(2);
    endtask

    task automatic ball(input int x, input int y, input int t1, input int t2);
        i_Ball_X = 6'(x); i_Ball_Y = 6'(y);
        i_Paddle_Y_P1 = 6'(t1); i_Paddle_Y_P2 = 6'(t2);
        model_ball(x, y, t1, t2);
        cyc(1);
        i_Ball_X = 6'd20;
        cyc(2);
    endtask

    task automatic direct_check(input string name, input logic [14:0] exp);
        logic [14:0] got;
        got = dut_tuple();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every change of the output bundle is one transition and must match the next expectation.
    always @(negedge i_Clk) begin
        logic [14:0] cur, exp;
        cur = dut_tuple();
        if (cur !== prev_tuple) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got st=%0d act=%0b dir=%0b p1=%0d p2=%0d win=%0d, expected no change",
                         cur[14:12], cur[11], cur[10], cur[9:6], cur[5:2], cur[1:0]);
            end else begin
                exp = sb.pop_front();
                if (cur !== exp) begin
                    errors++;
                    $display("FAIL transition: got st=%0d act=%0b dir=%0b p1=%0d p2=%0d win=%0d, expected st=%0d act=%0b dir=%0b p1=%0d p2=%0d win=%0d",
                             cur[14:12], cur[11], cur[10], cur[9:6], cur[5:2], cur[1:0],
                             exp[14:12], exp[11], exp[10], exp[9:6], exp[5:2], exp[1:0]);
                end
            end
        end
        prev_tuple = cur;
    end

    initial begin
        int wait_cnt;
        // Reset state
        #2 i_Rst_L = 1'b0;
        #1 direct_check("reset_state", RESET_TUPLE);
        cyc(2);
        i_Rst_L = 1'b1;
        cyc(2);

        // 1: start, exactly three frame ticks to RUNNING
        press();
        repeat (SERVE) frame();

        // 2: P1 misses, P2 scores, serve toward P1
        ball(0, 20, 5, 10);
        repeat (SERVE) frame();

        // 3: P2 paddle rows 10..15; row 15 is a hit, row 16 a miss
        ball(GW - 1, 15, 5, 10);
        ball(GW - 1, 10, 5, 10);
        ball(0, 5, 5, 10);
        ball(0, 10, 5, 10);
        ball(GW - 1, 16, 5, 10);

        // 4: P1 runs to the limit, match over, back to IDLE with scores held
        while (m_state != M_OVER && m_state != M_IDLE) begin
            repeat (SERVE) frame();
            ball(GW - 1, 40, 5, 10);
        end
        repeat (WINF) frame();
        cyc(4);

        // Start pulse and frame tick in the same IDLE cycle: full serve count still applies
        i_VSync = 1'b1;
        cyc(2);
        i_VSync = 1'b0;
        i_Game_Start = 1'b1;
        model_frame();
        model_start();
        cyc(2);
        i_Game_Start = 1'b0;
        cyc(2);
        repeat (SERVE) frame();

        // 5: P2 wins while start is held through the end of the match
        while (m_state != M_OVER) begin
            ball(0, 50, 5, 10);
            if (m_state == M_SERVE) repeat (SERVE) frame();
        end
        i_Game_Start = 1'b1;
        model_start();
        cyc(2);
        repeat (WINF) frame();
        cyc(6);
        i_Game_Start = 1'b0;
        cyc(2);
        press();
        repeat (SERVE) frame();

        // Asynchronous reset during RUNNING
        ball(GW - 1, 12, 5, 10);
        i_Rst_L = 1'b0;
        model_reset();
        push_expect();
        #1 direct_check("async_reset_running", RESET_TUPLE);
        cyc(2);
        i_Rst_L = 1'b1;
        cyc(2);

        // Randomized play against the model
        for (int i = 0; i < 400; i++) begin
            int r, x, y, t1, t2;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                frame();
            end else if (r == 5) begin
                press();
            end else begin
                case ($urandom_range(0, 2))
                    0: x = 0;
                    1: x = GW - 1;
                    default: x = $urandom_range(0, 63);
                endcase
                y  = $urandom_range(0, 63);
                t1 = $urandom_range(0, 63);
                t2 = $urandom_range(0, 63);
                ball(x, y, t1, t2);
            end
        end

        // Drain scoreboard within a bounded time
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            cyc(1);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
